// File: rtl/pipe_id_scoreboard.sv
// ID-stage operand unit: register file, E/M/W forwarding, countdown
// scoreboard for long-latency results, MUL occupancy FSM, ID branch resolve.
module pipe_id_scoreboard #(
    parameter int XLEN    = 32,
    parameter int NREG    = 32,
    parameter int LD_LAT  = 1,
    parameter int MUL_LAT = 4,
    localparam int AW     = $clog2(NREG)
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            id_valid,
    input  logic [AW-1:0]   id_rs,
    input  logic [AW-1:0]   id_rt,
    input  logic            id_use_rs,
    input  logic            id_use_rt,
    input  logic            id_wr,
    input  logic [AW-1:0]   id_rd,
    input  logic [1:0]      id_kind,
    input  logic [1:0]      id_br,
    input  logic            e_wreg,
    input  logic [AW-1:0]   e_rn,
    input  logic [XLEN-1:0] e_alu,
    input  logic            m_wreg,
    input  logic [AW-1:0]   m_rn,
    input  logic [XLEN-1:0] m_alu,
    input  logic            m_m2reg,
    input  logic [XLEN-1:0] m_mo,
    input  logic            w_wreg,
    input  logic [AW-1:0]   w_rn,
    input  logic [XLEN-1:0] w_di,
    output logic [XLEN-1:0] da,
    output logic [XLEN-1:0] db,
    output logic [1:0]      fwda,
    output logic [1:0]      fwdb,
    output logic            stall,
    output logic            bubble,
    output logic            br_taken,
    output logic            mul_busy
);

    localparam int MAXL = (LD_LAT > MUL_LAT) ? LD_LAT : MUL_LAT;
    localparam int CW   = $clog2(MAXL + 1);

    typedef enum logic {
        IDLE,
        BUSY
    } state_t;

    logic [XLEN-1:0] rf  [NREG];
    logic [CW-1:0]   cnt [NREG];

    state_t        state;
    logic [CW-1:0] mcnt;

    logic          issue;
    logic          is_ld;
    logic          is_mul;
    logic [CW-1:0] lat;
    logic          dep_rs;
    logic          dep_rt;
    logic          dep_stall;
    logic          struct_stall;
    logic          busy;

    // Priority E > M > W > RF; r0 never forwards and always reads zero.
    function automatic logic [XLEN+1:0] resolve(input logic [AW-1:0] src);
        logic [XLEN-1:0] v;
        logic [1:0]      f;
        v = rf[src];
        f = 2'd0;
        if (src == '0) begin
            v = '0;
            f = 2'd0;
        end else if (e_wreg && e_rn == src) begin
            v = e_alu;
            f = 2'd1;
        end else if (m_wreg && m_rn == src) begin
            v = m_m2reg ? m_mo : m_alu;
            f = 2'd2;
        end else if (w_wreg && w_rn == src) begin
            v = w_di;
            f = 2'd3;
        end
        return {f, v};
    endfunction

    always_comb begin
        {fwda, da} = resolve(id_rs);
        {fwdb, db} = resolve(id_rt);
    end

    always_comb begin
        is_ld  = (id_kind == 2'd1);
        is_mul = (id_kind == 2'd2);
        lat    = '0;
        unique case (1'b1)
            is_ld:   lat = CW'(LD_LAT);
            is_mul:  lat = CW'(MUL_LAT - 1);
            default: lat = '0;
        endcase
    end

    always_comb begin
        busy         = (state == BUSY);
        dep_rs       = id_use_rs && (id_rs != '0) && (cnt[id_rs] != '0);
        dep_rt       = id_use_rt && (id_rt != '0) && (cnt[id_rt] != '0);
        dep_stall    = dep_rs || dep_rt;
        struct_stall = busy && id_valid;
        stall        = dep_stall || struct_stall;
        bubble       = id_valid && stall;
        issue        = id_valid && !stall;
        mul_busy     = busy;
        br_taken     = issue &&
                       (((id_br == 2'd1) && (da == db)) ||
                        ((id_br == 2'd2) && (da != db)));
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < NREG; i++) rf[i] <= '0;
        end else if (w_wreg && w_rn != '0) begin
            rf[w_rn] <= w_di;
        end
    end

    // Issue write placed after the decrement so it wins for the same entry.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < NREG; i++) cnt[i] <= '0;
        end else begin
            for (int i = 0; i < NREG; i++) begin
                if (cnt[i] != '0) cnt[i] <= cnt[i] - CW'(1);
            end
            if (issue && id_wr && id_rd != '0) cnt[id_rd] <= lat;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
            mcnt  <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (issue && is_mul) begin
                        state <= BUSY;
                        mcnt  <= CW'(MUL_LAT - 1);
                    end
                end
                BUSY: begin
                    mcnt <= mcnt - CW'(1);
                    if (mcnt == CW'(1)) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pipe_id_scoreboard.sv
// Directed bench for pipe_id_scoreboard: forwarding vector table plus
// load-use, MUL occupancy and reset-mid-MUL sequences.
module tb_pipe_id_scoreboard;

    logic        clock = 1'b0;
    logic        reset;
    logic        id_valid;
    logic [4:0]  id_rs, id_rt, id_rd;
    logic        id_use_rs, id_use_rt, id_wr;
    logic [1:0]  id_kind, id_br;
    logic        e_wreg, m_wreg, m_m2reg, w_wreg;
    logic [4:0]  e_rn, m_rn, w_rn;
    logic [31:0] e_alu, m_alu, m_mo, w_di;
    logic [31:0] da, db;
    logic [1:0]  fwda, fwdb;
    logic        stall, bubble, br_taken, mul_busy;

    int total = 0;
    int bad   = 0;

    always #5 clock = ~clock;

    pipe_id_scoreboard dut (
        .clock(clock), .reset(reset), .id_valid(id_valid),
        .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs),
        .id_use_rt(id_use_rt), .id_wr(id_wr), .id_rd(id_rd),
        .id_kind(id_kind), .id_br(id_br),
        .e_wreg(e_wreg), .e_rn(e_rn), .e_alu(e_alu),
        .m_wreg(m_wreg), .m_rn(m_rn), .m_alu(m_alu),
        .m_m2reg(m_m2reg), .m_mo(m_mo),
        .w_wreg(w_wreg), .w_rn(w_rn), .w_di(w_di),
        .da(da), .db(db), .fwda(fwda), .fwdb(fwdb),
        .stall(stall), .bubble(bubble), .br_taken(br_taken),
        .mul_busy(mul_busy)
    );

    typedef struct {
        logic [4:0]  rs, rt;
        logic        ew;
        logic [4:0]  ern;
        logic [31:0] ealu;
        logic        mw;
        logic [4:0]  mrn;
        logic [31:0] malu;
        logic        m2;
        logic [31:0] mo;
        logic        ww;
        logic [4:0]  wrn;
        logic [31:0] wdi;
        logic [1:0]  br;
        logic [31:0] xda, xdb;
        logic [1:0]  xfa, xfb;
        logic        xbr;
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic clr;
        id_valid = 0; id_rs = 0; id_rt = 0; id_rd = 0;
        id_use_rs = 0; id_use_rt = 0; id_wr = 0;
        id_kind = 0; id_br = 0;
        e_wreg = 0; e_rn = 0; e_alu = 0;
        m_wreg = 0; m_rn = 0; m_alu = 0; m_m2reg = 0; m_mo = 0;
        w_wreg = 0; w_rn = 0; w_di = 0;
    endtask

    task automatic wb(input logic [4:0] r, input logic [31:0] v);
        clr();
        w_wreg = 1; w_rn = r; w_di = v;
        tick();
    endtask

    initial begin
        vecs[0] = '{rs: 5'd1, rt: 5'd2, xda: 32'h5, xdb: 32'h7,
                    default: '0};
        vecs[1] = '{rs: 5'd3, rt: 5'd0, ew: 1'b1, ern: 5'd3,
                    ealu: 32'h11, xda: 32'h11, xfa: 2'd1, default: '0};
        vecs[2] = '{rs: 5'd1, rt: 5'd2, ww: 1'b1, wrn: 5'd2, wdi: 32'h5,
                    br: 2'd1, xda: 32'h5, xdb: 32'h5, xfb: 2'd3,
                    xbr: 1'b1, default: '0};
        vecs[3] = '{rs: 5'd1, rt: 5'd2, ww: 1'b1, wrn: 5'd2, wdi: 32'h5,
                    br: 2'd2, xda: 32'h5, xdb: 32'h5, xfb: 2'd3,
                    default: '0};
        vecs[4] = '{rs: 5'd0, rt: 5'd4, ew: 1'b1, ern: 5'd0,
                    ealu: 32'hE0, mw: 1'b1, mrn: 5'd0, malu: 32'hA0,
                    ww: 1'b1, wrn: 5'd0, wdi: 32'hDEAD,
                    xdb: 32'h44, default: '0};
        vecs[5] = '{rs: 5'd4, rt: 5'd4, ew: 1'b1, ern: 5'd4,
                    ealu: 32'hE4, mw: 1'b1, mrn: 5'd4, malu: 32'hA4,
                    xda: 32'hE4, xdb: 32'hE4, xfa: 2'd1, xfb: 2'd1,
                    default: '0};
        vecs[6] = '{rs: 5'd4, rt: 5'd6, mw: 1'b1, mrn: 5'd4,
                    malu: 32'h1, m2: 1'b1, mo: 32'hCAFE,
                    ww: 1'b1, wrn: 5'd6, wdi: 32'h99,
                    xda: 32'hCAFE, xdb: 32'h99, xfa: 2'd2, xfb: 2'd3,
                    default: '0};
        vecs[7] = '{rs: 5'd6, rt: 5'd4, br: 2'd2, xda: 32'h99,
                    xdb: 32'h44, xbr: 1'b1, default: '0};
        vecs[8] = '{rs: 5'd6, rt: 5'd1, mw: 1'b1, mrn: 5'd6,
                    malu: 32'h77, ww: 1'b1, wrn: 5'd6, wdi: 32'h55,
                    br: 2'd1, xda: 32'h77, xdb: 32'h5, xfa: 2'd2,
                    default: '0};
        vecs[9] = '{rs: 5'd1, rt: 5'd1, br: 2'd3, xda: 32'h5,
                    xdb: 32'h5, default: '0};

        clr();
        reset = 1;
        repeat (2) @(posedge clock);
        #1 reset = 0;

        id_valid = 1; id_use_rs = 1; id_rs = 5'd1;
        #1;
        chk("rst_stall", 32'(stall), 32'd0);
        chk("rst_bubble", 32'(bubble), 32'd0);
        chk("rst_br", 32'(br_taken), 32'd0);
        chk("rst_busy", 32'(mul_busy), 32'd0);
        chk("rst_rf", da, 32'd0);
        tick();

        wb(5'd1, 32'h5);
        wb(5'd2, 32'h7);
        wb(5'd4, 32'h44);
        wb(5'd6, 32'h66);

        for (int i = 0; i < 10; i++) begin
            clr();
            id_valid = 1; id_use_rs = 1; id_use_rt = 1;
            id_rs = vecs[i].rs; id_rt = vecs[i].rt; id_br = vecs[i].br;
            e_wreg = vecs[i].ew; e_rn = vecs[i].ern; e_alu = vecs[i].ealu;
            m_wreg = vecs[i].mw; m_rn = vecs[i].mrn; m_alu = vecs[i].malu;
            m_m2reg = vecs[i].m2; m_mo = vecs[i].mo;
            w_wreg = vecs[i].ww; w_rn = vecs[i].wrn; w_di = vecs[i].wdi;
            #1;
            chk($sformatf("v%0d_da", i), da, vecs[i].xda);
            chk($sformatf("v%0d_db", i), db, vecs[i].xdb);
            chk($sformatf("v%0d_fwda", i), 32'(fwda), 32'(vecs[i].xfa));
            chk($sformatf("v%0d_fwdb", i), 32'(fwdb), 32'(vecs[i].xfb));
            chk($sformatf("v%0d_br", i), 32'(br_taken), 32'(vecs[i].xbr));
            chk($sformatf("v%0d_stall", i), 32'(stall), 32'd0);
            tick();
        end

        // load-use on r5
        clr();
        id_valid = 1; id_wr = 1; id_rd = 5'd5; id_kind = 2'd1;
        #1 chk("ld_issue_stall", 32'(stall), 32'd0);
        tick();
        clr();
        id_valid = 1; id_use_rs = 1; id_rs = 5'd5;
        #1;
        chk("ld_use_stall", 32'(stall), 32'd1);
        chk("ld_use_bubble", 32'(bubble), 32'd1);
        tick();
        m_wreg = 1; m_rn = 5'd5; m_m2reg = 1; m_mo = 32'hCAFE;
        m_alu = 32'h123;
        #1;
        chk("ld_fwd_stall", 32'(stall), 32'd0);
        chk("ld_fwda", 32'(fwda), 32'd2);
        chk("ld_da", da, 32'hCAFE);
        tick();

        // MUL on r7 followed by dependent instruction
        clr();
        id_valid = 1; id_wr = 1; id_rd = 5'd7; id_kind = 2'd2;
        #1;
        chk("mul_issue_stall", 32'(stall), 32'd0);
        chk("mul_issue_busy", 32'(mul_busy), 32'd0);
        tick();
        clr();
        id_valid = 1; id_use_rs = 1; id_rs = 5'd7;
        for (int c = 0; c < 3; c++) begin
            #1;
            chk($sformatf("mul_c%0d_stall", c), 32'(stall), 32'd1);
            chk($sformatf("mul_c%0d_bubble", c), 32'(bubble), 32'd1);
            chk($sformatf("mul_c%0d_busy", c), 32'(mul_busy), 32'd1);
            tick();
        end
        e_wreg = 1; e_rn = 5'd7; e_alu = 32'h777;
        #1;
        chk("mul_done_busy", 32'(mul_busy), 32'd0);
        chk("mul_done_stall", 32'(stall), 32'd0);
        chk("mul_fwda", 32'(fwda), 32'd1);
        chk("mul_da", da, 32'h777);
        tick();

        // reset in the middle of a MUL on r8
        clr();
        id_valid = 1; id_wr = 1; id_rd = 5'd8; id_kind = 2'd2;
        tick();
        clr();
        #1 chk("rmul_busy_before", 32'(mul_busy), 32'd1);
        reset = 1;
        repeat (2) tick();
        reset = 0;
        id_valid = 1; id_use_rs = 1; id_rs = 5'd8;
        id_use_rt = 1; id_rt = 5'd1;
        #1;
        chk("rmul_busy", 32'(mul_busy), 32'd0);
        chk("rmul_stall", 32'(stall), 32'd0);
        chk("rmul_rf_r1", db, 32'd0);
        chk("rmul_fwdb", 32'(fwdb), 32'd0);
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
